// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with per-register busy scoreboard
// Register 0 reads as zero; optional same-cycle write forwarding onto the read ports.
module register_file_mp #(
  parameter int DW     = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NWR-1:0]           wen,
  input  logic [NWR-1:0][AW-1:0]   wsel,
  input  logic [NWR-1:0][DW-1:0]   wdat,
  input  logic [NRD-1:0][AW-1:0]   rsel,
  output logic [NRD-1:0][DW-1:0]   rdat,
  output logic [NRD-1:0]           rbusy,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  output logic [AW:0]              npend
);

  logic [NREGS-1:0][DW-1:0] r_data;
  logic [NREGS-1:0]         r_busy;
  logic [AW:0]              r_npend;

  logic [NREGS-1:0][DW-1:0] w_data_nxt;
  logic [NREGS-1:0]         w_busy_nxt;
  logic [AW:0]              w_npend_nxt;

  // Later write ports overwrite earlier ones; the reservation is applied last so it wins.
  always_comb begin
    w_data_nxt = r_data;
    w_busy_nxt = r_busy;
    for (int i = 0; i < NWR; i++) begin
      if (wen[i] && (wsel[i] != '0)) begin
        w_data_nxt[wsel[i]] = wdat[i];
        w_busy_nxt[wsel[i]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_sel != '0)) begin
      w_busy_nxt[rsv_sel] = 1'b1;
    end
    w_data_nxt[0] = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_npend_nxt = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_npend_nxt = w_npend_nxt + {{AW{1'b0}}, w_busy_nxt[k]};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_data  <= '0;
      r_busy  <= '0;
      r_npend <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_npend <= w_npend_nxt;
    end
  end

  // Reads are gated by reset so forwarded write data cannot leak out while nRST is low.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      rdat[j]  = r_data[rsel[j]];
      rbusy[j] = r_busy[rsel[j]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wen[i] && (wsel[i] == rsel[j])) begin
            rdat[j]  = wdat[i];
            rbusy[j] = 1'b0;
          end
        end
      end
      if ((rsel[j] == '0) || !nRST) begin
        rdat[j]  = '0;
        rbusy[j] = 1'b0;
      end
    end
  end

  assign npend = r_npend;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - bench for register_file_mp, forwarding and non-forwarding builds
// Array-based reference model checked on every falling edge, plus directed literal checks.
module tb_register_file_mp;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        wen;
  logic [1:0][4:0]   wsel;
  logic [1:0][31:0]  wdat;
  logic [1:0][4:0]   rsel;
  logic              rsv_en;
  logic [4:0]        rsv_sel;
  logic [1:0][31:0]  rdat_b, rdat_n;
  logic [1:0]        rbusy_b, rbusy_n;
  logic [5:0]        npend_b, npend_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_data [32];
  bit          m_busy [32];

  register_file_mp #(.BYPASS(1)) u_byp (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
    .rdat(rdat_b), .rbusy(rbusy_b), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .npend(npend_b)
  );

  register_file_mp #(.BYPASS(0)) u_nobyp (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
    .rdat(rdat_n), .rbusy(rbusy_n), .rsv_en(rsv_en), .rsv_sel(rsv_sel), .npend(npend_n)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdat(input int j, input bit byp);
    logic [31:0] v;
    if (rsel[j] == 5'd0) return 32'd0;
    v = m_data[rsel[j]];
    if (byp) begin
      for (int i = 0; i < 2; i++)
        if (wen[i] && wsel[i] == rsel[j]) v = wdat[i];
    end
    return v;
  endfunction

  function automatic bit exp_rbusy(input int j, input bit byp);
    if (rsel[j] == 5'd0) return 1'b0;
    if (byp) begin
      for (int i = 0; i < 2; i++)
        if (wen[i] && wsel[i] == rsel[j]) return 1'b0;
    end
    return m_busy[rsel[j]];
  endfunction

  // Sole owner of the model: checks outputs, then commits this cycle's inputs to the model.
  initial begin
    for (int k = 0; k < 32; k++) begin m_data[k] = '0; m_busy[k] = 1'b0; end
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        for (int j = 0; j < 2; j++) begin
          chk($sformatf("rst_rdat_byp[%0d]", j), 64'(rdat_b[j]), 64'd0);
          chk($sformatf("rst_rdat_nobyp[%0d]", j), 64'(rdat_n[j]), 64'd0);
          chk($sformatf("rst_rbusy_byp[%0d]", j), 64'(rbusy_b[j]), 64'd0);
          chk($sformatf("rst_rbusy_nobyp[%0d]", j), 64'(rbusy_n[j]), 64'd0);
        end
        chk("rst_npend_byp", 64'(npend_b), 64'd0);
        chk("rst_npend_nobyp", 64'(npend_n), 64'd0);
        for (int k = 0; k < 32; k++) begin m_data[k] = '0; m_busy[k] = 1'b0; end
      end else begin
        int cnt;
        cnt = 0;
        for (int k = 0; k < 32; k++) cnt += int'(m_busy[k]);
        chk("npend_byp", 64'(npend_b), 64'(cnt));
        chk("npend_nobyp", 64'(npend_n), 64'(cnt));
        for (int j = 0; j < 2; j++) begin
          chk($sformatf("rdat_byp[%0d]", j), 64'(rdat_b[j]), 64'(exp_rdat(j, 1'b1)));
          chk($sformatf("rdat_nobyp[%0d]", j), 64'(rdat_n[j]), 64'(exp_rdat(j, 1'b0)));
          chk($sformatf("rbusy_byp[%0d]", j), 64'(rbusy_b[j]), 64'(exp_rbusy(j, 1'b1)));
          chk($sformatf("rbusy_nobyp[%0d]", j), 64'(rbusy_n[j]), 64'(exp_rbusy(j, 1'b0)));
        end
        for (int i = 0; i < 2; i++) begin
          if (wen[i] && wsel[i] != 5'd0) begin
            m_data[wsel[i]] = wdat[i];
            m_busy[wsel[i]] = 1'b0;
          end
        end
        if (rsv_en && rsv_sel != 5'd0) m_busy[rsv_sel] = 1'b1;
      end
    end
  end

  task automatic set_in(input logic [1:0] we, input logic [4:0] ws0, input logic [31:0] wd0,
                        input logic [4:0] ws1, input logic [31:0] wd1,
                        input logic re, input logic [4:0] rs, input logic [4:0] r0, input logic [4:0] r1);
    wen = we; wsel[0] = ws0; wdat[0] = wd0; wsel[1] = ws1; wdat[1] = wd1;
    rsv_en = re; rsv_sel = rs; rsel[0] = r0; rsel[1] = r1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    nRST = 1'b0;
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    #2 chk("lit_reset_npend", 64'(npend_b), 64'd0);

    // Two write ports collide on r7: port 1 wins.
    step(); set_in(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    #2 chk("lit_conflict_fwd", 64'(rdat_b[0]), 64'h22);
    chk("lit_conflict_nofwd", 64'(rdat_n[0]), 64'h0);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    #2 chk("lit_conflict_stored", 64'(rdat_n[1]), 64'h22);

    // r0 is immune to writes and reservations.
    step(); set_in(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    #2 chk("lit_r0_rdat", 64'(rdat_b[0]), 64'h0);
    chk("lit_r0_rbusy", 64'(rbusy_b[0]), 64'h0);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2 chk("lit_r0_npend", 64'(npend_b), 64'd0);

    // Scoreboard round trip on r3.
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3);
    #2 chk("lit_rsv_same_cycle", 64'(rbusy_b[0]), 64'd0);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    #2 chk("lit_rsv_rbusy", 64'(rbusy_b[0]), 64'd1);
    chk("lit_rsv_npend", 64'(npend_b), 64'd1);
    step(); set_in(2'b01, 5'd3, 32'h5, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    #2 chk("lit_wr_rbusy_fwd", 64'(rbusy_b[0]), 64'd0);
    chk("lit_wr_rdat_fwd", 64'(rdat_b[0]), 64'h5);
    chk("lit_wr_rbusy_nofwd", 64'(rbusy_n[0]), 64'd1);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    #2 chk("lit_wr_npend", 64'(npend_b), 64'd0);
    chk("lit_wr_rdat_nofwd", 64'(rdat_n[0]), 64'h5);

    // Reserve and write collide on busy r9: data lands, busy stays.
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    step(); set_in(2'b10, 5'd0, 32'd0, 5'd9, 32'hA, 1'b1, 5'd9, 5'd9, 5'd9);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    #2 chk("lit_coll_rdat", 64'(rdat_b[0]), 64'hA);
    chk("lit_coll_rbusy", 64'(rbusy_b[0]), 64'd1);
    chk("lit_coll_npend", 64'(npend_b), 64'd1);

    // Non-forwarding build sees the write one cycle late.
    step(); set_in(2'b01, 5'd4, 32'h33, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    #2 chk("lit_nobyp_old", 64'(rdat_n[0]), 64'h0);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    #2 chk("lit_nobyp_new", 64'(rdat_n[0]), 64'h33);

    // Mid-cycle asynchronous reset.
    step(); set_in(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    step(); set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    #2 chk("lit_r5_loaded", 64'(rdat_b[0]), 64'hDEAD_BEEF);
    nRST = 1'b0;
    #1 chk("lit_async_rdat", 64'(rdat_b[0]), 64'h0);
    chk("lit_async_npend", 64'(npend_b), 64'd0);
    step(); nRST = 1'b1;

    repeat (3000) begin
      step();
      nRST = ($urandom_range(0, 299) != 0);
      set_in(2'($urandom_range(0, 3)), rnd_addr(), $urandom(), rnd_addr(), $urandom(),
             1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
    end
    step();
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
